// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: byte width, memory depth and
// the PRGA state encoding.
package arc4_pkg;

    localparam int BYTE_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_WAIT,
        PT0_WR,
        I_RD,
        I_WAIT,
        J_RD,
        J_WAIT,
        WR_I,
        WR_J,
        PAD_RD,
        PAD_WAIT,
        PT_WR
    } prga_state_t;

endpackage

// File: rtl/prga_if.sv
// PRGA control handshake plus S, ciphertext and plaintext
// memory ports.
interface prga_if;
    import arc4_pkg::*;

    logic  en;
    logic  rdy;
    byte_t addr_s;
    byte_t rddata_s;
    byte_t wrdata_s;
    logic  wren_s;
    byte_t addr_ct;
    byte_t rddata_ct;
    byte_t addr_pt;
    byte_t wrdata_pt;
    logic  wren_pt;

    modport master (
        input  en,
        input  rddata_s,
        input  rddata_ct,
        output rdy,
        output addr_s,
        output wrdata_s,
        output wren_s,
        output addr_ct,
        output addr_pt,
        output wrdata_pt,
        output wren_pt
    );

    modport slave (
        output en,
        output rddata_s,
        output rddata_ct,
        input  rdy,
        input  addr_s,
        input  wrdata_s,
        input  wren_s,
        input  addr_ct,
        input  addr_pt,
        input  wrdata_pt,
        input  wren_pt
    );

endinterface

// File: rtl/prga.sv
// RC4 keystream generation and decrypt over a ksa-scheduled S.
// All memory ports are driven combinationally from state.
module prga (
    input  logic   clk,
    input  logic   rst_n,
    prga_if.master bus
);
    import arc4_pkg::*;

    prga_state_t state;
    prga_state_t state_nxt;

    byte_t i;
    byte_t j;
    byte_t k;
    byte_t len;
    byte_t si;
    byte_t sj;
    byte_t pad;
    byte_t ct;
    byte_t pad_a;

    assign pad_a = si + sj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            len <= '0;
            si  <= '0;
            sj  <= '0;
            pad <= '0;
            ct  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.en) begin
                        i <= '0;
                        j <= '0;
                    end
                end
                LEN_WAIT: begin
                    len <= bus.rddata_ct;
                    k   <= 8'd1;
                end
                I_RD: i <= i + 8'd1;
                I_WAIT: begin
                    si <= bus.rddata_s;
                    j  <= j + bus.rddata_s;
                end
                J_WAIT: sj <= bus.rddata_s;
                PAD_WAIT: begin
                    pad <= bus.rddata_s;
                    ct  <= bus.rddata_ct;
                end
                // test before increment so len=255 never wraps k
                PT_WR: begin
                    if (k != len) begin
                        k <= k + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.rdy       = 1'b0;
        bus.addr_s    = '0;
        bus.wrdata_s  = '0;
        bus.wren_s    = 1'b0;
        bus.addr_ct   = '0;
        bus.addr_pt   = '0;
        bus.wrdata_pt = '0;
        bus.wren_pt   = 1'b0;
        unique case (state)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) begin
                    state_nxt = LEN_RD;
                end
            end
            LEN_RD: state_nxt = LEN_WAIT;
            LEN_WAIT: state_nxt = PT0_WR;
            PT0_WR: begin
                bus.wrdata_pt = len;
                bus.wren_pt   = 1'b1;
                state_nxt     = (len != '0) ? I_RD : IDLE;
            end
            I_RD: begin
                bus.addr_s = i + 8'd1;
                state_nxt  = I_WAIT;
            end
            I_WAIT: state_nxt = J_RD;
            J_RD: begin
                bus.addr_s = j;
                state_nxt  = J_WAIT;
            end
            J_WAIT: state_nxt = WR_I;
            WR_I: begin
                bus.addr_s   = i;
                bus.wrdata_s = sj;
                bus.wren_s   = 1'b1;
                state_nxt    = WR_J;
            end
            WR_J: begin
                bus.addr_s   = j;
                bus.wrdata_s = si;
                bus.wren_s   = 1'b1;
                state_nxt    = PAD_RD;
            end
            PAD_RD: begin
                bus.addr_s  = pad_a;
                bus.addr_ct = k;
                state_nxt   = PAD_WAIT;
            end
            PAD_WAIT: state_nxt = PT_WR;
            PT_WR: begin
                bus.addr_pt   = k;
                bus.wrdata_pt = pad ^ ct;
                bus.wren_pt   = 1'b1;
                state_nxt     = (k == len) ? IDLE : I_RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Scoreboard bench for prga: RC4 reference model feeds expected
// plaintext writes, popped as the DUT issues them.
module tb_prga;
    import arc4_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    prga_if bus ();

    prga dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    byte_t s_mem  [MEM_DEPTH];
    byte_t ct_mem [MEM_DEPTH];
    byte_t s_init [MEM_DEPTH];
    byte_t ct_init[MEM_DEPTH];
    byte_t sm     [MEM_DEPTH];

    logic  ld   = 1'b0;
    byte_t ld_a = '0;

    logic [15:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int s_wr_cnt;
    int both_cnt;

    always @(posedge clk) begin
        if (ld) begin
            s_mem[ld_a]  <= s_init[ld_a];
            ct_mem[ld_a] <= ct_init[ld_a];
        end else if (bus.wren_s) begin
            s_mem[bus.addr_s] <= bus.wrdata_s;
        end
        bus.rddata_s  <= s_mem[bus.addr_s];
        bus.rddata_ct <= ct_mem[bus.addr_ct];
    end

    task automatic load_mems();
        for (int x = 0; x < MEM_DEPTH; x++) begin
            @(negedge clk);
            ld   = 1'b1;
            ld_a = byte_t'(x);
        end
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic ksa_model(input logic [23:0] key);
        byte_t kb[3];
        byte_t jj;
        byte_t t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int x = 0; x < MEM_DEPTH; x++) s_init[x] = byte_t'(x);
        jj = '0;
        for (int x = 0; x < MEM_DEPTH; x++) begin
            jj = jj + s_init[x] + kb[x % 3];
            t = s_init[x];
            s_init[x] = s_init[jj];
            s_init[jj] = t;
        end
    endtask

    task automatic model_rc4();
        byte_t i;
        byte_t j;
        byte_t t;
        byte_t idx;
        byte_t len;
        exp_q.delete();
        for (int x = 0; x < MEM_DEPTH; x++) sm[x] = s_init[x];
        len = ct_init[0];
        exp_q.push_back({8'h00, len});
        i = '0;
        j = '0;
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            j = j + sm[i];
            t = sm[i];
            sm[i] = sm[j];
            sm[j] = t;
            idx = sm[i] + sm[j];
            exp_q.push_back({byte_t'(k), ct_init[k] ^ sm[idx]});
        end
    endtask

    task automatic run(input bit hold, input int pulse_at);
        logic [15:0] e;
        s_wr_cnt = 0;
        both_cnt = 0;
        lat = -1;
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            bus.en = hold || (c == pulse_at);
            if (bus.rdy) begin
                lat = c - 1;
                break;
            end
            if (bus.wren_s) s_wr_cnt++;
            if (bus.wren_s && bus.wren_pt) both_cnt++;
            if (bus.wren_pt) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pt_extra: got %h@%h, want no write",
                             bus.wrdata_pt, bus.addr_pt);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.addr_pt, bus.wrdata_pt} !== e) begin
                        n_bad++;
                        $display("FAIL pt_byte: got %h@%h, want %h@%h",
                                 bus.wrdata_pt, bus.addr_pt, e[7:0], e[15:8]);
                    end
                end
            end
        end
        n_cmp++;
        if (lat < 0) begin
            n_bad++;
            $display("FAIL run_timeout: got no rdy, want rdy");
        end
    endtask

    task automatic check_tail(input string nm, input int want_lat);
        int diffs;
        diffs = 0;
        n_cmp++;
        if (lat !== want_lat) begin
            n_bad++;
            $display("FAIL %s_lat: got %0d, want %0d", nm, lat, want_lat);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_missing: got %0d unwritten, want 0", nm,
                     exp_q.size());
        end
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL %s_dual_wr: got %0d, want 0", nm, both_cnt);
        end
        for (int x = 0; x < MEM_DEPTH; x++) begin
            if (s_mem[x] !== sm[x]) diffs++;
        end
        n_cmp++;
        if (diffs !== 0) begin
            n_bad++;
            $display("FAIL %s_s_final: got %0d bad bytes, want 0", nm, diffs);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_rdy: got %b, want 1", bus.rdy);
        end
        n_cmp++;
        if ({bus.wren_s, bus.wren_pt} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_wren: got %b, want 00",
                     {bus.wren_s, bus.wren_pt});
        end
        n_cmp++;
        if ({bus.addr_s, bus.addr_ct, bus.addr_pt} !== 24'h0) begin
            n_bad++;
            $display("FAIL rst_addr: got %h, want 0",
                     {bus.addr_s, bus.addr_ct, bus.addr_pt});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_len();
        for (int x = 0; x < MEM_DEPTH; x++) begin
            s_init[x]  = byte_t'(x);
            ct_init[x] = 8'h00;
        end
        load_mems();
        model_rc4();
        run(1'b0, 0);
        check_tail("zero", 3);
        n_cmp++;
        if (s_wr_cnt !== 0) begin
            n_bad++;
            $display("FAIL zero_s_wr: got %0d, want 0", s_wr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        model_rc4();
        run(1'b1, 0);
        check_tail("b2b1", 3);
        @(negedge clk);
        n_cmp++;
        if (bus.rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_restart: got rdy %b, want 0", bus.rdy);
        end
        bus.en = 1'b0;
        c = 1;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (bus.rdy) break;
        end
        n_cmp++;
        if (c - 1 !== 3) begin
            n_bad++;
            $display("FAIL b2b2_lat: got %0d, want 3", c - 1);
        end
    endtask

    task automatic test_identity();
        for (int x = 0; x < MEM_DEPTH; x++) begin
            s_init[x]  = byte_t'(x);
            ct_init[x] = 8'h00;
        end
        ct_init[0] = 8'h01;
        load_mems();
        model_rc4();
        exp_q.delete();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0102);
        run(1'b0, 6);
        check_tail("ident", 12);
    endtask

    task automatic load_known();
        byte_t kct[10];
        kct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        ksa_model(24'h4B6579);
        for (int x = 0; x < MEM_DEPTH; x++) ct_init[x] = 8'h00;
        for (int x = 0; x < 10; x++) ct_init[x] = kct[x];
        load_mems();
    endtask

    task automatic push_known();
        byte_t kpt[10];
        kpt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69,
                8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        model_rc4();
        exp_q.delete();
        for (int x = 0; x < 10; x++) exp_q.push_back({byte_t'(x), kpt[x]});
    endtask

    task automatic test_known_vector();
        load_known();
        push_known();
        run(1'b0, 0);
        check_tail("known", 84);
    endtask

    task automatic test_busy_reset();
        load_known();
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            bus.en = (c == 5);
        end
        n_cmp++;
        if (bus.wren_s !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_wr_i: got wren_s %b, want 1", bus.wren_s);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rdy, bus.wren_s, bus.wren_pt} !== 3'b100) begin
            n_bad++;
            $display("FAIL midrst_out: got %b, want 100",
                     {bus.rdy, bus.wren_s, bus.wren_pt});
        end
        n_cmp++;
        if (bus.addr_s !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_addr: got %h, want 00", bus.addr_s);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.wren_s, bus.wren_pt} !== 2'b00) begin
            n_bad++;
            $display("FAIL midrst_hold: got %b, want 00",
                     {bus.wren_s, bus.wren_pt});
        end
        rst_n = 1'b1;
        load_mems();
        push_known();
        run(1'b0, 0);
        check_tail("rerun", 84);
    endtask

    task automatic test_max_len();
        ksa_model(24'h1A2B3C);
        for (int x = 0; x < MEM_DEPTH; x++) begin
            ct_init[x] = byte_t'($urandom_range(0, 255));
        end
        ct_init[0] = 8'hFF;
        load_mems();
        model_rc4();
        run(1'b0, 0);
        check_tail("max", 2298);
        n_cmp++;
        if (s_wr_cnt !== 510) begin
            n_bad++;
            $display("FAIL max_s_wr: got %0d, want 510", s_wr_cnt);
        end
    endtask

    initial begin
        bus.en = 1'b0;
        test_reset();
        test_zero_len();
        test_back_to_back();
        test_identity();
        test_known_vector();
        test_busy_reset();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  start request; sampled only at a rising edge where rdy=1.
REQ-004 rdy  output  1  high iff idle and able to accept en.
REQ-005 addr_s  output  8  S-memory address.
REQ-006 rddata_s  input  8  S-memory read data, valid one cycle after address presented.
REQ-007 wrdata_s  output  8  S-memory write data.
REQ-008 wren_s  output  1  S-memory write enable.
REQ-009 addr_ct  output  8  ciphertext-memory address (read-only memory).
REQ-010 rddata_ct  input  8  ciphertext read data, one-cycle latency.
REQ-011 addr_pt  output  8  plaintext-memory address.
REQ-012 wrdata_pt  output  8  plaintext write data.
REQ-013 wren_pt  output  1  plaintext write enable.

Function
REQ-014 Block shall run the RC4 keystream/decrypt pass over S as left by ksa: length L=CT[0], PT[0]=L, for k=1..L: i=i+1, j=j+S[i], swap S[i],S[j], PT[k]=CT[k] xor S[S[i]+S[j]]; all sums mod 256; i=j=0 at start of each run.
REQ-015 States: IDLE, LEN_RD, LEN_WAIT, PT0_WR, I_RD, I_WAIT, J_RD, J_WAIT, WR_I, WR_J, PAD_RD, PAD_WAIT, PT_WR; one cycle each except IDLE.
REQ-016 IDLE -> LEN_RD when en=1; en ignored in all other states.
REQ-017 LEN_RD: addr_ct=0. LEN_WAIT: capture L. PT0_WR: addr_pt=0, wrdata_pt=L, wren_pt=1; then I_RD if L>0, else IDLE.
REQ-018 I_RD: i<=i+1, addr_s=new i. I_WAIT: si<=rddata_s, j<=j+rddata_s. J_RD: addr_s=j. J_WAIT: sj<=rddata_s.
REQ-019 WR_I: addr_s=i, wrdata_s=sj, wren_s=1. WR_J: addr_s=j, wrdata_s=si, wren_s=1 (i==j yields unchanged S).
REQ-020 PAD_RD: addr_s=si+sj mod 256, addr_ct=k. PAD_WAIT: capture pad and CT[k]. PT_WR: addr_pt=k, wrdata_pt=pad xor CT[k], wren_pt=1; then IDLE if k==L else k<=k+1, I_RD.
REQ-021 Latency: rdy returns high exactly 3+9L cycles after the accepting edge; L=0 gives 3, L=255 gives 2298.
REQ-022 k shall be compared to L before increment so L=255 terminates without 8-bit overflow.
REQ-023 Write enables high only in WR_I, WR_J, PT0_WR, PT_WR; never both wren_s and wren_pt in one cycle.
REQ-024 en held high continuously shall start a new run on the first rdy=1 edge after completion.

Reset
REQ-025 rst_n=0 shall immediately force IDLE, rdy=1, wren_s=wren_pt=0, all addresses/write data/i/j/k/L=0, regardless of state.
REQ-026 Reset mid-run shall abandon the run; S/PT memory contents are not restored; correct output then requires re-running init and ksa.

Structure
REQ-027 Shared package arc4_pkg shall hold the prga state enum, BYTE_W=8, MEM_DEPTH=256.
REQ-028 Block shall be flat (no sub-modules); arc4 top shall instantiate it after ksa, muxing the shared S-memory port by stage.

Verification
REQ-029 Reset: rst_n=0 -> rdy=1, wren_s=0, wren_pt=0 without a clock edge.
REQ-030 Zero length: CT[0]=0, en pulse -> PT[0]=0, no S writes, rdy high 3 cycles later.
REQ-031 Identity S (S[x]=x), CT={01,00} -> PT={01,02}, S unchanged, rdy after 12 cycles.
REQ-032 Known vector: S from ksa with key 24'h4B6579, CT={09,BB,F3,16,E8,D9,40,AF,0A,D3} -> PT={09,50,6C,61,69,6E,74,65,78,74} ("Plaintext").
REQ-033 Busy/reset: en pulsed during run -> ignored; rst_n low during k=3 -> rdy=1 and writes stop at once; re-init + rerun -> correct PT.
REQ-034 Max length: CT[0]=FF -> 255 PT writes, j wraps correctly against model, rdy after 2298 cycles.
